// File: rtl/microcode_sequencer_pkg.sv
// Shared definitions for the microcode sequencer: op encodings, condition
// indices used by the CPU, and a stack-pointer width helper.
package microcode_sequencer_pkg;

    typedef enum logic [2:0] {
        UC_NEXT = 3'd0,
        UC_JUMP = 3'd1,
        UC_CALL = 3'd2,
        UC_RET  = 3'd3,
        UC_MAP  = 3'd4,
        UC_LDCT = 3'd5,
        UC_LOOP = 3'd6,
        UC_HOLD = 3'd7
    } uc_op_e;

    localparam int COND_ZERO  = 0;
    localparam int COND_CARRY = 1;
    localparam int COND_NEG   = 2;
    localparam int COND_OVF   = 3;

    // Occupancy needs to represent 0..depth inclusive.
    function automatic int stack_ptr_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/microcode_sequencer_stack.sv
// Return-address LIFO. Contents are not reset; only the occupancy counter is.
// Push when full and pop when empty are ignored; the parent raises the flags.
module microcode_sequencer_stack
    import microcode_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 12,
    localparam int SP_W  = stack_ptr_w(DEPTH),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    push_data,
    output logic [W-1:0]    top_data,
    output logic            full,
    output logic            empty,
    output logic [SP_W-1:0] sp
);

    logic [W-1:0]     mem [0:(2**IDX_W)-1];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign full     = (sp == SP_W'(DEPTH));
    assign empty    = (sp == '0);
    assign wr_idx   = IDX_W'(sp);
    assign rd_idx   = IDX_W'(sp - SP_W'(1));
    assign top_data = mem[rd_idx];

    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Next-address generator for the microcoded CPU: condition select, next-address
// mux, loop counter, return stack and sticky overflow/underflow flags.
module microcode_sequencer
    import microcode_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4,
    parameter int NCOND       = 8,
    parameter int CNT_W       = 8,
    localparam int CSEL_W = $clog2(NCOND),
    localparam int SP_W   = stack_ptr_w(STACK_DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic [2:0]        op,
    input  logic [CSEL_W-1:0] cond_sel,
    input  logic              cond_pol,
    input  logic [NCOND-1:0]  cond_in,
    input  logic [ADDR_W-1:0] d_in,
    input  logic [ADDR_W-1:0] map_in,
    output logic [ADDR_W-1:0] uc_addr,
    output logic [SP_W-1:0]   sp,
    output logic              cnt_zero,
    output logic              stk_ovf,
    output logic              stk_unf
);

    logic              cc;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] addr_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              unf_set;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] top_data;

    assign cc       = cond_in[cond_sel] ^ cond_pol;
    assign inc      = uc_addr + ADDR_W'(1);
    assign cnt_zero = (cnt == '0);

    always_comb begin
        addr_nxt = inc;
        cnt_nxt  = cnt;
        push     = 1'b0;
        pop      = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        case (uc_op_e'(op))
            UC_NEXT: addr_nxt = inc;
            UC_JUMP: if (cc) addr_nxt = d_in;
            UC_CALL: begin
                if (cc) begin
                    addr_nxt = d_in;
                    if (full) ovf_set = 1'b1;
                    else      push    = 1'b1;
                end
            end
            UC_RET: begin
                if (cc) begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        pop      = 1'b1;
                        addr_nxt = top_data;
                    end
                end
            end
            UC_MAP:  addr_nxt = map_in;
            UC_LDCT: cnt_nxt  = d_in[CNT_W-1:0];
            UC_LOOP: begin
                if (!cnt_zero) begin
                    cnt_nxt  = cnt - CNT_W'(1);
                    addr_nxt = d_in;
                end
            end
            UC_HOLD: addr_nxt = uc_addr;
            default: addr_nxt = inc;
        endcase
    end

    microcode_sequencer_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push && !stall),
        .pop       (pop && !stall),
        .push_data (inc),
        .top_data  (top_data),
        .full      (full),
        .empty     (empty),
        .sp        (sp)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uc_addr <= '0;
            cnt     <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (!stall) begin
            uc_addr <= addr_nxt;
            cnt     <= cnt_nxt;
            if (ovf_set) stk_ovf <= 1'b1;
            if (unf_set) stk_unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench: directed scenarios plus randomized ops, all checked
// every cycle against a queue-based behavioural model of the sequencer.
module tb_microcode_sequencer;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;
    localparam int NCOND  = 8;
    localparam int CNT_W  = 8;
    localparam int ROM    = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              stall = 1'b0;
    logic [2:0]        op = 3'd0;
    logic [2:0]        cond_sel = 3'd0;
    logic              cond_pol = 1'b0;
    logic [NCOND-1:0]  cond_in = '0;
    logic [ADDR_W-1:0] d_in = '0;
    logic [ADDR_W-1:0] map_in = '0;
    logic [ADDR_W-1:0] uc_addr;
    logic [2:0]        sp;
    logic              cnt_zero;
    logic              stk_ovf;
    logic              stk_unf;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int m_addr, m_cnt, m_ovf, m_unf;
    int m_stk[$];

    microcode_sequencer #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (DEPTH),
        .NCOND       (NCOND),
        .CNT_W       (CNT_W)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .stall    (stall),
        .op       (op),
        .cond_sel (cond_sel),
        .cond_pol (cond_pol),
        .cond_in  (cond_in),
        .d_in     (d_in),
        .map_in   (map_in),
        .uc_addr  (uc_addr),
        .sp       (sp),
        .cnt_zero (cnt_zero),
        .stk_ovf  (stk_ovf),
        .stk_unf  (stk_unf)
    );

    always #5 clock = ~clock;

    // Behavioural model: address as an integer modulo ROM size, stack as a queue.
    always @(posedge clock or negedge reset_n) begin
        int inc;
        bit cc;
        if (!reset_n) begin
            m_addr = 0;
            m_cnt  = 0;
            m_ovf  = 0;
            m_unf  = 0;
            m_stk.delete();
        end else if (!stall) begin
            cc  = cond_in[cond_sel] ^ cond_pol;
            inc = (m_addr + 1) % ROM;
            case (op)
                3'd0: m_addr = inc;
                3'd1: m_addr = cc ? int'(d_in) : inc;
                3'd2: begin
                    if (cc) begin
                        if (m_stk.size() == DEPTH) m_ovf = 1;
                        else m_stk.push_back(inc);
                        m_addr = d_in;
                    end else m_addr = inc;
                end
                3'd3: begin
                    if (cc && m_stk.size() > 0) m_addr = m_stk.pop_back();
                    else begin
                        if (cc) m_unf = 1;
                        m_addr = inc;
                    end
                end
                3'd4: m_addr = map_in;
                3'd5: begin
                    m_cnt  = d_in % (1 << CNT_W);
                    m_addr = inc;
                end
                3'd6: begin
                    if (m_cnt != 0) begin
                        m_cnt  = m_cnt - 1;
                        m_addr = d_in;
                    end else m_addr = inc;
                end
                default: m_addr = m_addr;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("uc_addr", uc_addr, m_addr);
            check("sp", sp, m_stk.size());
            check("cnt_zero", cnt_zero, m_cnt == 0);
            check("stk_ovf", stk_ovf, m_ovf);
            check("stk_unf", stk_unf, m_unf);
        end
    end

    // Hand-computed expectations, applied to both the DUT and the model.
    task automatic lit(input string name, input int exp_addr, input int exp_sp);
        check({name, "_addr"}, uc_addr, exp_addr);
        check({name, "_model_addr"}, m_addr, exp_addr);
        check({name, "_sp"}, sp, exp_sp);
    endtask

    task automatic drive(input logic [2:0] o, input logic [ADDR_W-1:0] d,
                         input logic [2:0] sel = 3'd3, input logic pol = 1'b0,
                         input logic [NCOND-1:0] cin = 8'h08,
                         input logic [ADDR_W-1:0] map = '0, input logic st = 1'b0);
        op       = o;
        d_in     = d;
        cond_sel = sel;
        cond_pol = pol;
        cond_in  = cin;
        map_in   = map;
        stall    = st;
        @(posedge clock);
        #1;
    endtask

    initial begin
        @(posedge clock);
        #1;
        chk_en = 1'b1;
        lit("reset", 0, 0);
        check("reset_ovf", stk_ovf, 0);
        check("reset_unf", stk_unf, 0);
        check("reset_cz", cnt_zero, 1);
        reset_n = 1'b1;

        for (int i = 1; i <= 5; i++) begin
            drive(3'd0, '0);
            lit("next", i, 0);
        end
        reset_n = 1'b0;
        #1;
        check("async_reset_addr", uc_addr, 0);
        #2;
        reset_n = 1'b1;

        drive(3'd1, 12'h100);
        lit("jump_taken", 12'h100, 0);
        drive(3'd1, 12'h200, 3'd3, 1'b1);
        lit("jump_inv", 12'h101, 0);

        drive(3'd1, 12'h010);
        drive(3'd2, 12'h200);
        lit("call", 12'h200, 1);
        drive(3'd3, '0);
        lit("ret", 12'h011, 0);

        for (int i = 0; i < 5; i++) drive(3'd2, 12'h300 + 12'(i));
        lit("call5", 12'h304, 4);
        check("ovf_after_5", stk_ovf, 1);
        for (int i = 0; i < 5; i++) drive(3'd3, '0);
        lit("ret5", 12'h013, 0);
        check("unf_after_5", stk_unf, 1);

        drive(3'd5, 12'h003);
        lit("ldct", 12'h014, 0);
        for (int i = 0; i < 3; i++) begin
            drive(3'd6, 12'h040);
            lit("loop_taken", 12'h040, 0);
        end
        drive(3'd6, 12'h040);
        lit("loop_exit", 12'h041, 0);
        check("loop_cz", cnt_zero, 1);

        drive(3'd5, 12'h002);
        for (int i = 0; i < 3; i++) drive(3'd6, 12'h040, 3'd3, 1'b0, 8'h08, '0, 1'b1);
        lit("stall_loop", 12'h042, 0);
        check("stall_cz", cnt_zero, 0);
        for (int i = 0; i < 3; i++) drive(3'd2, 12'h500, 3'd3, 1'b0, 8'h08, '0, 1'b1);
        lit("stall_call", 12'h042, 0);
        drive(3'd6, 12'h040);
        lit("loop_after_stall", 12'h040, 0);

        drive(3'd1, 12'hFFF);
        drive(3'd0, '0);
        lit("wrap", 12'h000, 0);
        drive(3'd4, 12'h123, 3'd3, 1'b0, 8'h00, 12'h0A5);
        lit("map", 12'h0A5, 0);
        drive(3'd7, 12'h123);
        lit("hold", 12'h0A5, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 399) begin
                reset_n = 1'b0;
                #3;
                reset_n = 1'b1;
            end
            drive(3'($urandom_range(0, 7)), 12'($urandom_range(0, ROM - 1)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 12'($urandom_range(0, ROM - 1)),
                  ($urandom_range(0, 9) == 0));
        end

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
